zigzag_serializer: RTL and testbench
====================================

Name: zigzag_serializer

Overview:
- Sits directly downstream of the per-channel quantizers (Y/Cb/Cr) and upstream of the run-length/Huffman entropy coder.
- Captures a full parallel 8x8 block of quantized coefficients on the quantizer's one-cycle out_enable pulse.
- Emits the 64 coefficients serially in JPEG zigzag order over a valid/ready stream.
- Uses a two-bank ping-pong buffer so one block can be captured while the previous block drains.

Parameters:
- COEF_W, 11, signed coefficient width (input and output).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_enable  in  1  one-cycle capture strobe (quantizer out_enable).
- Q  in  COEF_W x [0:7][0:7]  signed quantized block, Q[row][col]; sampled only when in_enable=1.
- coef_out  out  COEF_W  signed coefficient in zigzag order.
- coef_valid  out  1  coef_out/coef_index/coef_last valid.
- coef_ready  in  1  downstream accept; a beat transfers when coef_valid & coef_ready.
- coef_index  out  6  zigzag position 0..63 of coef_out (0 = DC).
- coef_last  out  1  high on index 63.
- busy  out  1  high while either bank is full.
- drop_err  out  1  sticky; set when a block is discarded.
- last_nz_index  out  6  see Optional Feature.

Behaviour:
- Reset (async, rst_n=0) clears all outputs: coef_out=0, coef_valid=0, coef_index=0, coef_last=0, busy=0, drop_err=0, last_nz_index=0.
- Reset also clears both bank-full flags, the write pointer wp=0, the read pointer rp=0 and the beat counter. Bank contents are don't-care.
- Reset mid-block abandons the block; no partial beats follow deassertion.
- Storage: two banks of 64 x COEF_W. Each bank has a full flag.
- Capture on in_enable=1:
  - If bank[wp] is not full, copy all 64 Q values into it in one edge, set full[wp], toggle wp.
  - If both banks are full, discard the block and set drop_err=1. drop_err stays set until reset.
- Read FSM has two states:
  - IDLE: coef_valid=0. When full[rp]=1, go to STREAM with beat counter k=0.
  - STREAM:
    - coef_valid=1, coef_out=bank[rp][ZZ[k]], coef_index=k, coef_last=(k==63). These outputs are registered.
    - Outputs hold stable while coef_valid & !coef_ready.
    - On a handshake with k<63: k increments.
    - On a handshake with k==63: clear full[rp], toggle rp. If full[other] is already set, stay in STREAM with k=0 (back-to-back, no bubble); otherwise go to IDLE.
- ZZ[k] is the standard JPEG zigzag LUT as row-major index row*8+col:
  - k 0..9 map to 0,1,8,16,9,2,3,10,17,24.
  - k 63 maps to 63.
- Latency: in_enable at edge N into an empty unit puts coef_valid=1 and coef_out=Q[0][0] after edge N+1.
- Throughput: 64 cycles per block with coef_ready held at 1.
- Simultaneous last-beat handshake and in_enable while both banks are full: the freeing bank is accepted. The free is evaluated before the capture; there is no drop.
- busy = full[0] | full[1].
- Coefficients pass unmodified; no saturation or rounding.

Optional Feature:
- Macro: ZIGZAG_EOB_DETECT_EN.
- Defined:
  - At capture, compute the highest zigzag index k with Q at ZZ[k] != 0 and store it per bank. Store 0 if the block is all-zero.
  - last_nz_index presents the stored value for bank rp while coef_valid=1.
  - The entropy coder uses it to emit EOB early.
- Undefined: last_nz_index is constant 63 and no extra logic is built.

Test Plan:
- Single block Q[r][c]=r*8+c, coef_ready=1:
  - coef_valid rises one cycle after in_enable.
  - Sequence starts 0,1,8,16,9,2,3,10,17,24 and ends at 63.
  - coef_last is high only on beat 64, then coef_valid=0.
- Backpressure: toggle coef_ready every cycle. Outputs are held while stalled, all 64 values arrive in order, and the block takes exactly 128 cycles.
- Three blocks pulsed 10 cycles apart with coef_ready=0:
  - Blocks A and B are stored, busy=1.
  - Block C is dropped and drop_err=1.
  - On releasing ready, A then B stream back-to-back with no gap between A's index 63 and B's index 0.
- Both banks full and in_enable coincident with A's last handshake: block C is accepted (drop_err stays 0) and streams after B.
- Async reset at beat 30: all outputs go to 0 immediately. After release, a new block streams starting at index 0.
- With ZIGZAG_EOB_DETECT_EN: a block with a nonzero coefficient only at Q[0][0] and Q[1][1] (zigzag 4) gives last_nz_index=4. An all-zero block gives 0.

Source files
------------

// File: rtl/zigzag_serializer.sv
// Captures a quantized 8x8 block into one of two ping-pong banks and streams it out in JPEG zigzag order.
// Optional macro ZIGZAG_EOB_DETECT_EN adds per-block last-nonzero zigzag index tracking.
module zigzag_serializer #(
   parameter int COEF_W = 11
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_enable,
   input  logic signed [COEF_W-1:0] Q [0:7][0:7],
   output logic signed [COEF_W-1:0] coef_out,
   output logic                     coef_valid,
   input  logic                     coef_ready,
   output logic [5:0]               coef_index,
   output logic                     coef_last,
   output logic                     busy,
   output logic                     drop_err,
   output logic [5:0]               last_nz_index
);

   localparam logic [5:0] ZZ_LUT [0:63] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   state_t                   state_r, state_s;
   logic [5:0]               k_r, k_s;
   logic                     rp_r, rp_s;
   logic                     wp_r, wp_s;
   logic [1:0]               full_r, full_s, full_free_s;
   logic signed [COEF_W-1:0] coef_out_r, coef_out_s;
   logic                     valid_r, valid_s;
   logic                     last_r, last_s;
   logic                     busy_r;
   logic                     drop_err_r;
   logic                     free_s, load_s, capture_s, drop_s;
   logic signed [COEF_W-1:0] bank_r [0:1][0:63];

   // Read FSM: next state, beat counter and bank release
   always_comb begin
      state_s = state_r;
      k_s     = k_r;
      rp_s    = rp_r;
      valid_s = valid_r;
      last_s  = last_r;
      free_s  = 1'b0;
      load_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (full_r[rp_r]) begin
               state_s = ST_STREAM;
               k_s     = 6'd0;
               valid_s = 1'b1;
               last_s  = 1'b0;
               load_s  = 1'b1;
            end else begin
               valid_s = 1'b0;
            end
         end
         ST_STREAM: begin
            if (coef_ready) begin
               if (k_r != 6'd63) begin
                  k_s    = k_r + 6'd1;
                  last_s = (k_r == 6'd62);
                  load_s = 1'b1;
               end else begin
                  // Block finished: release the bank and chain straight into the other one if it is ready
                  free_s = 1'b1;
                  rp_s   = ~rp_r;
                  k_s    = 6'd0;
                  last_s = 1'b0;
                  if (full_r[~rp_r]) begin
                     load_s = 1'b1;
                  end else begin
                     state_s = ST_IDLE;
                     valid_s = 1'b0;
                  end
               end
            end else begin
               state_s = ST_STREAM;
            end
         end
         default: begin
            state_s = ST_IDLE;
            k_s     = 6'd0;
            valid_s = 1'b0;
            last_s  = 1'b0;
         end
      endcase
   end

   // Output coefficient fetch from the bank being streamed
   always_comb begin
      if (load_s) begin
         coef_out_s = bank_r[rp_s][ZZ_LUT[k_s]];
      end else begin
         coef_out_s = coef_out_r;
      end
   end

   // Bank occupancy: the release of a drained bank is applied before the capture decision
   always_comb begin
      full_free_s = full_r;
      if (free_s) begin
         full_free_s[rp_r] = 1'b0;
      end else begin
         full_free_s = full_r;
      end
      capture_s = in_enable & ~full_free_s[wp_r];
      drop_s    = in_enable & full_free_s[wp_r];
      full_s    = full_free_s;
      wp_s      = wp_r;
      if (capture_s) begin
         full_s[wp_r] = 1'b1;
         wp_s         = ~wp_r;
      end else begin
         wp_s = wp_r;
      end
   end

   // Control and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         k_r        <= 6'd0;
         rp_r       <= 1'b0;
         wp_r       <= 1'b0;
         full_r     <= 2'b00;
         coef_out_r <= {COEF_W{1'b0}};
         valid_r    <= 1'b0;
         last_r     <= 1'b0;
         busy_r     <= 1'b0;
         drop_err_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         k_r        <= k_s;
         rp_r       <= rp_s;
         wp_r       <= wp_s;
         full_r     <= full_s;
         coef_out_r <= coef_out_s;
         valid_r    <= valid_s;
         last_r     <= last_s;
         busy_r     <= |full_s;
         drop_err_r <= drop_err_r | drop_s;
      end
   end

   // Block capture storage; contents need no reset
   always_ff @(posedge clk) begin
      if (capture_s) begin
         for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
               bank_r[wp_r][6'(r * 8 + c)] <= Q[r][c];
            end
         end
      end
   end

   assign coef_out   = coef_out_r;
   assign coef_valid = valid_r;
   assign coef_index = k_r;
   assign coef_last  = last_r;
   assign busy       = busy_r;
   assign drop_err   = drop_err_r;

`ifdef ZIGZAG_EOB_DETECT_EN
   logic [5:0] lnz_bank_r [0:1];
   logic [5:0] lnz_cap_s;
   logic [5:0] last_nz_r, last_nz_s;

   // Highest zigzag position holding a nonzero coefficient in the incoming block
   always_comb begin
      lnz_cap_s = 6'd0;
      for (int k = 0; k < 64; k++) begin
         if (Q[ZZ_LUT[k][5:3]][ZZ_LUT[k][2:0]] != {COEF_W{1'b0}}) begin
            lnz_cap_s = 6'(k);
         end else begin
            lnz_cap_s = lnz_cap_s;
         end
      end
   end

   // Presented value follows the bank being streamed
   always_comb begin
      if (load_s) begin
         last_nz_s = lnz_bank_r[rp_s];
      end else if (valid_s) begin
         last_nz_s = last_nz_r;
      end else begin
         last_nz_s = 6'd0;
      end
   end

   // Per-bank storage of the capture-time scan result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lnz_bank_r[0] <= 6'd0;
         lnz_bank_r[1] <= 6'd0;
         last_nz_r     <= 6'd0;
      end else begin
         if (capture_s) begin
            lnz_bank_r[wp_r] <= lnz_cap_s;
         end
         last_nz_r <= last_nz_s;
      end
   end

   assign last_nz_index = last_nz_r;
`else
   assign last_nz_index = 6'd63;
`endif

endmodule

// File: tb/tb_zigzag_serializer.sv
// Directed bench for zigzag_serializer: latency, ordering, backpressure, ping-pong, drop, coincident free/capture, async reset.
module tb_zigzag_serializer;

   localparam int COEF_W = 11;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     in_enable = 1'b0;
   logic                     coef_ready = 1'b0;
   logic signed [COEF_W-1:0] q_s [0:7][0:7];
   logic signed [COEF_W-1:0] coef_out;
   logic                     coef_valid;
   logic [5:0]               coef_index;
   logic                     coef_last;
   logic                     busy;
   logic                     drop_err;
   logic [5:0]               last_nz_index;

   int vectors = 0;
   int miscompares = 0;
   int zz [0:63];

   zigzag_serializer #(.COEF_W(COEF_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_enable     (in_enable),
      .Q             (q_s),
      .coef_out      (coef_out),
      .coef_valid    (coef_valid),
      .coef_ready    (coef_ready),
      .coef_index    (coef_index),
      .coef_last     (coef_last),
      .busy          (busy),
      .drop_err      (drop_err),
      .last_nz_index (last_nz_index)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Distinct value pattern per test block, indexed by row-major position
   function automatic int blkval(input int b, input int idx);
      case (b)
         0:       return idx;
         1:       return 100 + idx;
         2:       return -200 + idx;
         default: return 500 - idx;
      endcase
   endfunction

   task automatic load_block(input int b);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            q_s[r][c] = 11'(blkval(b, r * 8 + c));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse();
      in_enable = 1'b1;
      tick();
      in_enable = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_valid(input int limit);
      int n;
      n = 0;
      while (!coef_valid && n < limit) begin
         tick();
         n++;
      end
      check("wait_valid", coef_valid, 1);
   endtask

   task automatic check_beat(input string tag, input int b, input int k);
      check({tag, "_valid"}, coef_valid, 1);
      check({tag, "_out"}, coef_out, blkval(b, zz[k]));
      check({tag, "_index"}, coef_index, k);
      check({tag, "_last"}, coef_last, (k == 63));
   endtask

   initial begin : main
      int kk, lo, hi, n, k;
      // Zigzag walk over anti-diagonals; even diagonals run bottom-left to top-right
      kk = 0;
      for (int s = 0; s < 15; s++) begin
         lo = (s > 7) ? s - 7 : 0;
         hi = (s < 7) ? s : 7;
         if (s % 2 == 0) begin
            for (int r = hi; r >= lo; r--) begin
               zz[kk] = r * 8 + (s - r);
               kk++;
            end
         end else begin
            for (int r = lo; r <= hi; r++) begin
               zz[kk] = r * 8 + (s - r);
               kk++;
            end
         end
      end

      load_block(0);
      tick();
      check("rst_valid", coef_valid, 0);
      check("rst_out", coef_out, 0);
      check("rst_index", coef_index, 0);
      check("rst_last", coef_last, 0);
      check("rst_busy", busy, 0);
      check("rst_drop", drop_err, 0);
`ifdef ZIGZAG_EOB_DETECT_EN
      check("rst_lnz", last_nz_index, 0);
`else
      check("lnz_const", last_nz_index, 63);
`endif
      rst_n = 1'b1;
      tick();

      // Single block, ready held high
      coef_ready = 1'b1;
      pulse();
      check("lat_valid_n", coef_valid, 0);
      check("lat_busy_n", busy, 1);
      tick();
      for (int j = 0; j < 64; j++) begin
         check_beat("single", 0, j);
         tick();
      end
      check("single_end_valid", coef_valid, 0);
      check("single_end_busy", busy, 0);

      // Backpressure: ready toggles, low on the first valid cycle
      load_block(3);
      coef_ready = 1'b0;
      pulse();
      wait_valid(5);
      n = 0;
      k = 0;
      while (k < 64 && n < 300) begin
         coef_ready = (n % 2 == 1);
         check_beat("bp", 3, k);
         if (coef_ready) k++;
         tick();
         n++;
      end
      check("bp_cycles", n, 128);
      check("bp_end_valid", coef_valid, 0);

      // Three blocks 10 cycles apart with ready low: A, B stored, C dropped
      coef_ready = 1'b0;
      load_block(0);
      pulse();
      repeat (9) tick();
      load_block(1);
      pulse();
      repeat (9) tick();
      check("ab_busy", busy, 1);
      check("ab_drop", drop_err, 0);
      check_beat("ab_hold", 0, 0);
      load_block(2);
      pulse();
      check("c_drop", drop_err, 1);
      check("c_busy", busy, 1);
      coef_ready = 1'b1;
      for (int j = 0; j < 128; j++) begin
         check_beat("b2b", j / 64, j % 64);
         tick();
      end
      check("b2b_end_valid", coef_valid, 0);
      check("b2b_drop_sticky", drop_err, 1);

      // Capture coincident with A's last handshake while both banks are full
      do_reset();
      check("coinc_rst_drop", drop_err, 0);
      coef_ready = 1'b0;
      load_block(0);
      pulse();
      load_block(1);
      pulse();
      coef_ready = 1'b1;
      for (int j = 0; j < 192; j++) begin
         check_beat("coinc", j / 64, j % 64);
         if (j == 63) begin
            check("coinc_busy_both", busy, 1);
            load_block(2);
            in_enable = 1'b1;
         end else begin
            in_enable = 1'b0;
         end
         tick();
      end
      in_enable = 1'b0;
      check("coinc_drop", drop_err, 0);
      check("coinc_end_valid", coef_valid, 0);

      // Asynchronous reset in the middle of a block
      load_block(1);
      pulse();
      tick();
      repeat (30) tick();
      check("arst_pre_index", coef_index, 30);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", coef_valid, 0);
      check("arst_out", coef_out, 0);
      check("arst_index", coef_index, 0);
      check("arst_last", coef_last, 0);
      check("arst_busy", busy, 0);
      tick();
      rst_n = 1'b1;
      tick();
      check("arst_no_partial", coef_valid, 0);
      load_block(3);
      pulse();
      tick();
      for (int j = 0; j < 64; j++) begin
         check_beat("post_rst", 3, j);
         tick();
      end
      check("post_rst_end_valid", coef_valid, 0);

`ifdef ZIGZAG_EOB_DETECT_EN
      // Nonzero only at Q[0][0] and Q[1][1] -> highest nonzero zigzag index 4
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            q_s[r][c] = 11'sd0;
      q_s[0][0] = 11'sd5;
      q_s[1][1] = 11'sd7;
      pulse();
      tick();
      check("eob_valid", coef_valid, 1);
      check("eob_lnz4", last_nz_index, 4);
      repeat (64) tick();
      q_s[0][0] = 11'sd0;
      q_s[1][1] = 11'sd0;
      pulse();
      tick();
      check("eob_zero_valid", coef_valid, 1);
      check("eob_lnz0", last_nz_index, 0);
      repeat (64) tick();
`else
      check("lnz_const_end", last_nz_index, 63);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
